// File: rtl/si_bullet_field_if.sv
// Bundle between the fire/player logic (master) and the bullet field (slave).
// Signal names follow the original shot-register board naming.
interface si_bullet_field_if #(
    parameter int ROWS  = 7,
    parameter int COLS  = 8,
    parameter int CNT_W = 8
);
    localparam int N  = ROWS * COLS;
    localparam int LW = $clog2(N + 1);

    logic             SI_BULLETFIELD_Clear_InLow;
    logic             SI_BULLETFIELD_Step_In;
    logic             SI_BULLETFIELD_Fire_In;
    logic [COLS-1:0]  SI_BULLETFIELD_FireCol_InBus;
    logic [N-1:0]     SI_BULLETFIELD_Target_InBus;
    logic [N-1:0]     SI_BULLETFIELD_Field_OutBus;
    logic [LW-1:0]    SI_BULLETFIELD_Live_OutBus;
    logic             SI_BULLETFIELD_FireAck_Out;
    logic             SI_BULLETFIELD_Escape_Out;
    logic             SI_BULLETFIELD_Hit_Out;
    logic [CNT_W-1:0] SI_BULLETFIELD_HitCount_OutBus;

    modport master (
        output SI_BULLETFIELD_Clear_InLow, SI_BULLETFIELD_Step_In, SI_BULLETFIELD_Fire_In,
               SI_BULLETFIELD_FireCol_InBus, SI_BULLETFIELD_Target_InBus,
        input  SI_BULLETFIELD_Field_OutBus, SI_BULLETFIELD_Live_OutBus, SI_BULLETFIELD_FireAck_Out,
               SI_BULLETFIELD_Escape_Out, SI_BULLETFIELD_Hit_Out, SI_BULLETFIELD_HitCount_OutBus
    );

    modport slave (
        input  SI_BULLETFIELD_Clear_InLow, SI_BULLETFIELD_Step_In, SI_BULLETFIELD_Fire_In,
               SI_BULLETFIELD_FireCol_InBus, SI_BULLETFIELD_Target_InBus,
        output SI_BULLETFIELD_Field_OutBus, SI_BULLETFIELD_Live_OutBus, SI_BULLETFIELD_FireAck_Out,
               SI_BULLETFIELD_Escape_Out, SI_BULLETFIELD_Hit_Out, SI_BULLETFIELD_HitCount_OutBus
    );
endinterface

// File: rtl/si_bullet_field.sv
// ROWS x COLS player-shot field: shift on Step, admit one-hot fires, remove bullets
// overlapping targets, count live bullets and saturating hits. All outputs registered.
module si_bullet_field #(
    parameter int ROWS        = 7,
    parameter int COLS        = 8,
    parameter int MAX_BULLETS = 4,
    parameter int CNT_W       = 8
) (
    input  logic                SI_BULLETFIELD_CLOCK_50,
    input  logic                SI_BULLETFIELD_RESET_InLow,
    si_bullet_field_if.slave    bus
);
    localparam int N  = ROWS * COLS;
    localparam int LW = $clog2(N + 1);
    localparam int SW = CNT_W + LW;

    logic [N-1:0]     field_q, field_d;
    logic [LW-1:0]    live_q, live_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             ack_q, ack_d, esc_q, esc_d, hit_q, hit_d;

    logic [COLS-1:0]  fc;
    logic [N-1:0]     shifted, staged, hits;
    logic             onehot, accept;
    logic [SW-1:0]    hsum;

    function automatic logic [LW-1:0] popcnt(input logic [N-1:0] v);
        logic [LW-1:0] n;
        n = '0;
        for (int i = 0; i < N; i++) n = n + LW'(v[i]);
        return n;
    endfunction

    assign fc     = bus.SI_BULLETFIELD_FireCol_InBus;
    assign onehot = (fc != '0) && ((fc & (fc - COLS'(1))) == '0);

    always_comb begin
        shifted = bus.SI_BULLETFIELD_Step_In ? {field_q[N-COLS-1:0], {COLS{1'b0}}} : field_q;
        esc_d   = bus.SI_BULLETFIELD_Step_In & (|field_q[N-1 -: COLS]);
        // Admission uses the registered count, so a same-cycle escape never frees a slot.
        accept  = bus.SI_BULLETFIELD_Fire_In && onehot &&
                  (live_q < LW'(MAX_BULLETS)) && ((shifted[COLS-1:0] & fc) == '0);
        staged  = shifted;
        if (accept) staged[COLS-1:0] = shifted[COLS-1:0] | fc;
        hits    = staged & bus.SI_BULLETFIELD_Target_InBus;
        field_d = staged & ~bus.SI_BULLETFIELD_Target_InBus;
        live_d  = popcnt(field_d);
        hsum    = SW'(hcnt_q) + SW'(popcnt(hits));
        hcnt_d  = (hsum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : hsum[CNT_W-1:0];
        ack_d   = accept;
        hit_d   = |hits;
        if (!bus.SI_BULLETFIELD_Clear_InLow) begin
            field_d = '0;
            live_d  = '0;
            hcnt_d  = '0;
            ack_d   = 1'b0;
            esc_d   = 1'b0;
            hit_d   = 1'b0;
        end
    end

    always_ff @(posedge SI_BULLETFIELD_CLOCK_50 or negedge SI_BULLETFIELD_RESET_InLow) begin
        if (!SI_BULLETFIELD_RESET_InLow) begin
            field_q <= '0;
            live_q  <= '0;
            hcnt_q  <= '0;
            ack_q   <= 1'b0;
            esc_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            field_q <= field_d;
            live_q  <= live_d;
            hcnt_q  <= hcnt_d;
            ack_q   <= ack_d;
            esc_q   <= esc_d;
            hit_q   <= hit_d;
        end
    end

    assign bus.SI_BULLETFIELD_Field_OutBus    = field_q;
    assign bus.SI_BULLETFIELD_Live_OutBus     = live_q;
    assign bus.SI_BULLETFIELD_HitCount_OutBus = hcnt_q;
    assign bus.SI_BULLETFIELD_FireAck_Out     = ack_q;
    assign bus.SI_BULLETFIELD_Escape_Out      = esc_q;
    assign bus.SI_BULLETFIELD_Hit_Out         = hit_q;
endmodule

// File: tb/tb_si_bullet_field.sv
// Bench for si_bullet_field: array-based field model checked every cycle, plus
// literal expectations for the directed scenarios. A CNT_W=2 copy checks saturation.
module tb_si_bullet_field;
    localparam int ROWS = 7, COLS = 8, MAXB = 4, N = ROWS * COLS;

    logic            clk, rst_n, clr_n, step, fire;
    logic [COLS-1:0] fc;
    logic [N-1:0]    tgt;
    int tests = 0, fails = 0;

    si_bullet_field_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(8)) bf ();
    si_bullet_field_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(2)) bf2 ();

    assign bf.SI_BULLETFIELD_Clear_InLow    = clr_n;
    assign bf.SI_BULLETFIELD_Step_In        = step;
    assign bf.SI_BULLETFIELD_Fire_In        = fire;
    assign bf.SI_BULLETFIELD_FireCol_InBus  = fc;
    assign bf.SI_BULLETFIELD_Target_InBus   = tgt;
    assign bf2.SI_BULLETFIELD_Clear_InLow   = clr_n;
    assign bf2.SI_BULLETFIELD_Step_In       = step;
    assign bf2.SI_BULLETFIELD_Fire_In       = fire;
    assign bf2.SI_BULLETFIELD_FireCol_InBus = fc;
    assign bf2.SI_BULLETFIELD_Target_InBus  = tgt;

    si_bullet_field #(.ROWS(ROWS), .COLS(COLS), .MAX_BULLETS(MAXB), .CNT_W(8)) dut (
        .SI_BULLETFIELD_CLOCK_50(clk), .SI_BULLETFIELD_RESET_InLow(rst_n), .bus(bf));
    si_bullet_field #(.ROWS(ROWS), .COLS(COLS), .MAX_BULLETS(MAXB), .CNT_W(2)) dut2 (
        .SI_BULLETFIELD_CLOCK_50(clk), .SI_BULLETFIELD_RESET_InLow(rst_n), .bus(bf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: field as a 2-D bit grid, counts as plain integers.
    bit mf[ROWS][COLS];
    int mlive = 0, mhc = 0, mhc2 = 0;
    bit mack = 0, mesc = 0, mhit = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit s[ROWS][COLS];
        int ones, col, nh;
        bit ok;
        if (!rst_n || !clr_n) begin
            for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) mf[r][c] = 0;
            mlive = 0; mhc = 0; mhc2 = 0; mack = 0; mesc = 0; mhit = 0;
        end else begin
            mesc = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    if (step) s[r][c] = (r == 0) ? 1'b0 : mf[r-1][c];
                    else      s[r][c] = mf[r][c];
                    if (step && r == ROWS - 1 && mf[r][c]) mesc = 1;
                end
            ones = 0; col = 0;
            for (int c = 0; c < COLS; c++) if (fc[c]) begin ones++; col = c; end
            ok = fire && ones == 1;
            if (ok && (mlive >= MAXB || s[0][col])) ok = 0;
            if (ok) s[0][col] = 1;
            mack = ok;
            nh = 0; mlive = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    if (s[r][c] && tgt[r*COLS + c]) begin nh++; s[r][c] = 0; end
                    mf[r][c] = s[r][c];
                    if (s[r][c]) mlive++;
                end
            mhit = nh > 0;
            mhc  = (mhc + nh > 255) ? 255 : mhc + nh;
            mhc2 = (mhc2 + nh > 3) ? 3 : mhc2 + nh;
        end
    end

    function automatic logic [N-1:0] mvec();
        logic [N-1:0] v;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) v[r*COLS + c] = mf[r][c];
        return v;
    endfunction

    always @(negedge clk) if (rst_n) begin
        chk("m_field", bf.SI_BULLETFIELD_Field_OutBus, mvec());
        chk("m_live",  bf.SI_BULLETFIELD_Live_OutBus, mlive);
        chk("m_ack",   bf.SI_BULLETFIELD_FireAck_Out, mack);
        chk("m_esc",   bf.SI_BULLETFIELD_Escape_Out, mesc);
        chk("m_hit",   bf.SI_BULLETFIELD_Hit_Out, mhit);
        chk("m_hc",    bf.SI_BULLETFIELD_HitCount_OutBus, mhc);
        chk("m_hc2",   bf2.SI_BULLETFIELD_HitCount_OutBus, mhc2);
    end

    task automatic go(input logic c, input logic s, input logic f,
                      input logic [COLS-1:0] col, input logic [N-1:0] t);
        clr_n = c; step = s; fire = f; fc = col; tgt = t;
        @(posedge clk); #1;
        clr_n = 1; step = 0; fire = 0; fc = '0; tgt = '0;
    endtask

    task automatic clear();
        go(0, 0, 0, '0, '0);
    endtask

    logic [63:0] e;
    logic [N-1:0] t27;

    initial begin
        rst_n = 0; clr_n = 1; step = 0; fire = 0; fc = '0; tgt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_field", bf.SI_BULLETFIELD_Field_OutBus, 0);
        chk("reset_live",  bf.SI_BULLETFIELD_Live_OutBus, 0);
        chk("reset_hc",    bf.SI_BULLETFIELD_HitCount_OutBus, 0);
        @(negedge clk); rst_n = 1;

        // T1/T2: single shot climbs and escapes
        go(1, 0, 1, 8'h08, '0);
        chk("t1_field", bf.SI_BULLETFIELD_Field_OutBus, 64'h08);
        chk("t1_ack",   bf.SI_BULLETFIELD_FireAck_Out, 1);
        chk("t1_live",  bf.SI_BULLETFIELD_Live_OutBus, 1);
        for (int k = 1; k <= 7; k++) begin
            go(1, 1, 0, '0, '0);
            e = 64'h08 << (8 * k);
            if (k < 7) chk("t2_row", bf.SI_BULLETFIELD_Field_OutBus, e);
        end
        chk("t2_esc",   bf.SI_BULLETFIELD_Escape_Out, 1);
        chk("t2_field", bf.SI_BULLETFIELD_Field_OutBus, 0);
        chk("t2_live",  bf.SI_BULLETFIELD_Live_OutBus, 0);
        go(1, 0, 0, '0, '0);
        chk("t2_esc_pulse", bf.SI_BULLETFIELD_Escape_Out, 0);

        // T3: occupied column, non-one-hot, empty column
        go(1, 0, 1, 8'h08, '0);
        chk("t3_ack1", bf.SI_BULLETFIELD_FireAck_Out, 1);
        go(1, 0, 1, 8'h08, '0);
        chk("t3_ack2", bf.SI_BULLETFIELD_FireAck_Out, 0);
        chk("t3_live", bf.SI_BULLETFIELD_Live_OutBus, 1);
        go(1, 0, 1, 8'h18, '0);
        chk("t3_two_hot", bf.SI_BULLETFIELD_FireAck_Out, 0);
        go(1, 0, 1, 8'h00, '0);
        chk("t3_zero", bf.SI_BULLETFIELD_FireAck_Out, 0);

        // T4: bullet limit, including step+fire at the limit
        clear();
        go(1, 0, 1, 8'h01, '0);
        go(1, 0, 1, 8'h02, '0);
        go(1, 0, 1, 8'h04, '0);
        go(1, 0, 1, 8'h08, '0);
        chk("t4_live4", bf.SI_BULLETFIELD_Live_OutBus, 4);
        go(1, 0, 1, 8'h10, '0);
        chk("t4_full_ack", bf.SI_BULLETFIELD_FireAck_Out, 0);
        chk("t4_full_live", bf.SI_BULLETFIELD_Live_OutBus, 4);
        go(1, 1, 1, 8'h10, '0);
        chk("t4_step_full", bf.SI_BULLETFIELD_FireAck_Out, 0);
        chk("t4_step_field", bf.SI_BULLETFIELD_Field_OutBus, 64'h0F00);

        // T5: collision and saturation
        clear();
        go(1, 0, 1, 8'h08, '0);
        go(1, 1, 0, '0, '0);
        go(1, 1, 0, '0, '0);
        chk("t5_row2", bf.SI_BULLETFIELD_Field_OutBus, 64'h08_0000);
        t27 = '0; t27[27] = 1'b1;
        go(1, 1, 0, '0, t27);
        chk("t5_field", bf.SI_BULLETFIELD_Field_OutBus, 0);
        chk("t5_hit",   bf.SI_BULLETFIELD_Hit_Out, 1);
        chk("t5_hc",    bf.SI_BULLETFIELD_HitCount_OutBus, 1);
        chk("t5_live",  bf.SI_BULLETFIELD_Live_OutBus, 0);
        for (int i = 0; i < 5; i++) begin
            go(1, 0, 1, 8'h08, 56'h08);
            chk("t5_fire_hit_ack", bf.SI_BULLETFIELD_FireAck_Out, 1);
            chk("t5_fire_hit", bf.SI_BULLETFIELD_Hit_Out, 1);
        end
        chk("t5_hc6", bf.SI_BULLETFIELD_HitCount_OutBus, 6);
        chk("t5_sat", bf2.SI_BULLETFIELD_HitCount_OutBus, 3);
        go(1, 0, 0, '0, '0);
        chk("t5_hit_pulse", bf.SI_BULLETFIELD_Hit_Out, 0);

        // T6: clear beats step/fire; async reset mid-cycle
        go(1, 0, 1, 8'h01, '0);
        go(0, 1, 1, 8'h10, '0);
        chk("t6_clr_field", bf.SI_BULLETFIELD_Field_OutBus, 0);
        chk("t6_clr_ack",   bf.SI_BULLETFIELD_FireAck_Out, 0);
        chk("t6_clr_hc",    bf.SI_BULLETFIELD_HitCount_OutBus, 0);
        go(1, 0, 1, 8'h01, '0);
        go(1, 0, 1, 8'h02, '0);
        go(1, 0, 1, 8'h04, 56'h40);
        chk("t6_live3", bf.SI_BULLETFIELD_Live_OutBus, 3);
        #1 rst_n = 0;
        #1;
        chk("t6_rst_field", bf.SI_BULLETFIELD_Field_OutBus, 0);
        chk("t6_rst_live",  bf.SI_BULLETFIELD_Live_OutBus, 0);
        chk("t6_rst_ack",   bf.SI_BULLETFIELD_FireAck_Out, 0);
        @(negedge clk); #2 rst_n = 1;
        go(1, 0, 1, 8'h80, '0);
        chk("t6_after_rst", bf.SI_BULLETFIELD_Field_OutBus, 64'h80);
        go(1, 0, 0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
